// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 4-bit CPU: owns PC, instruction register and
// carry flag, decodes instructions and strobes one register load per EXEC cycle.
module cpu_sequencer #(
    parameter int unsigned PC_W     = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk_cpu,
    input  logic            reset,
    input  logic            run,
    input  logic [7:0]      rom_data,
    input  logic            alu_carry,
    output logic [PC_W-1:0] rom_addr,
    output logic [1:0]      src_sel,
    output logic [3:0]      imm,
    output logic            load_a,
    output logic            load_b,
    output logic            load_out,
    output logic            carry_flag,
    output logic            exec
);

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned IMM_W   = 4;
    localparam int unsigned SRC_W   = 2;

    localparam logic [OP_W-1:0] OP_ADD_A_IM = 4'h0;
    localparam logic [OP_W-1:0] OP_MOV_A_B  = 4'h1;
    localparam logic [OP_W-1:0] OP_IN_A     = 4'h2;
    localparam logic [OP_W-1:0] OP_MOV_A_IM = 4'h3;
    localparam logic [OP_W-1:0] OP_MOV_B_A  = 4'h4;
    localparam logic [OP_W-1:0] OP_ADD_B_IM = 4'h5;
    localparam logic [OP_W-1:0] OP_IN_B     = 4'h6;
    localparam logic [OP_W-1:0] OP_MOV_B_IM = 4'h7;
    localparam logic [OP_W-1:0] OP_OUT_B    = 4'h9;
    localparam logic [OP_W-1:0] OP_OUT_IM   = 4'hB;
    localparam logic [OP_W-1:0] OP_JNC      = 4'hE;
    localparam logic [OP_W-1:0] OP_JMP      = 4'hF;

    localparam logic [SRC_W-1:0] SRC_A    = 2'd0;
    localparam logic [SRC_W-1:0] SRC_B    = 2'd1;
    localparam logic [SRC_W-1:0] SRC_IN   = 2'd2;
    localparam logic [SRC_W-1:0] SRC_ZERO = 2'd3;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_A    = 2'd1,
        DST_B    = 2'd2,
        DST_OUT  = 2'd3
    } dst_t;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                carry_q, carry_d;

    logic [OP_W-1:0]     opcode;
    logic [IMM_W-1:0]    ir_imm;
    dst_t                dst;
    logic [SRC_W-1:0]    src_dec;
    logic                is_add;
    logic                is_jmp;
    logic                is_jnc;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     jump_target;

    assign opcode      = ir_q[INSTR_W-1:IMM_W];
    assign ir_imm      = ir_q[IMM_W-1:0];
    assign pc_inc      = pc_q + PC_W'(1);
    assign jump_target = PC_W'(ir_imm);

    assign rom_addr   = pc_q;
    assign src_sel    = src_dec;
    assign imm        = ir_imm;
    assign carry_flag = carry_q;

    // Instruction decode from the latched IR; undefined opcodes behave as NOP
    always_comb begin
        dst     = DST_NONE;
        src_dec = SRC_ZERO;
        is_add  = 1'b0;
        is_jmp  = 1'b0;
        is_jnc  = 1'b0;
        case (opcode)
            OP_ADD_A_IM: begin dst = DST_A;   src_dec = SRC_A;    is_add = 1'b1; end
            OP_MOV_A_B:  begin dst = DST_A;   src_dec = SRC_B;    end
            OP_IN_A:     begin dst = DST_A;   src_dec = SRC_IN;   end
            OP_MOV_A_IM: begin dst = DST_A;   src_dec = SRC_ZERO; end
            OP_MOV_B_A:  begin dst = DST_B;   src_dec = SRC_A;    end
            OP_ADD_B_IM: begin dst = DST_B;   src_dec = SRC_B;    is_add = 1'b1; end
            OP_IN_B:     begin dst = DST_B;   src_dec = SRC_IN;   end
            OP_MOV_B_IM: begin dst = DST_B;   src_dec = SRC_ZERO; end
            OP_OUT_B:    begin dst = DST_OUT; src_dec = SRC_B;    end
            OP_OUT_IM:   begin dst = DST_OUT; src_dec = SRC_ZERO; end
            OP_JNC:      is_jnc = 1'b1;
            OP_JMP:      is_jmp = 1'b1;
            default:     dst = DST_NONE;
        endcase
    end

    // Next-state, PC/carry update and load strobes (strobes combinational so reset kills them at once)
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_out = 1'b0;
        exec     = 1'b0;
        case (state_q)
            FETCH: begin
                if (run) begin
                    ir_d    = rom_data;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec     = 1'b1;
                load_a   = (dst == DST_A);
                load_b   = (dst == DST_B);
                load_out = (dst == DST_OUT);
                carry_d  = is_add ? alu_carry : 1'b0;
                pc_d     = (is_jmp || (is_jnc && !carry_q)) ? jump_target : pc_inc;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= PC_W'(RESET_PC);
            ir_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed corner sequences, a table-driven program and
// a random program stream checked against an instruction-level reference model.
module tb_cpu_sequencer;

    logic       clk_cpu;
    logic       reset;
    logic       run;
    logic [7:0] rom_data;
    logic       alu_carry;
    logic [3:0] rom_addr;
    logic [1:0] src_sel;
    logic [3:0] imm;
    logic       load_a, load_b, load_out;
    logic       carry_flag;
    logic       exec;

    logic [7:0] rom [0:15];
    int n_vec = 0;
    int n_err = 0;

    int dest_tab [0:15];
    int src_tab  [0:15];
    logic [3:0] m_pc;
    logic       m_carry;

    typedef struct {
        logic [3:0] pc;
        logic [7:0] word;
        logic       alu;
        logic       drop;
        logic [2:0] load;
        logic [1:0] src;
        logic       src_chk;
        logic [3:0] npc;
        logic       ncarry;
    } vec_t;

    vec_t tbl [0:13];

    cpu_sequencer #(.PC_W(4), .RESET_PC(0)) dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .run        (run),
        .rom_data   (rom_data),
        .alu_carry  (alu_carry),
        .rom_addr   (rom_addr),
        .src_sel    (src_sel),
        .imm        (imm),
        .load_a     (load_a),
        .load_b     (load_b),
        .load_out   (load_out),
        .carry_flag (carry_flag),
        .exec       (exec)
    );

    assign rom_data = rom[rom_addr];

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full instruction starting from a FETCH negedge; returns at the following FETCH negedge
    task automatic apply_instr(input string tag, input logic [3:0] pc_before, input logic alu,
                               input logic drop, input logic [2:0] e_load, input logic [1:0] e_src,
                               input logic e_src_chk, input logic [3:0] e_imm,
                               input logic [3:0] e_pc, input logic e_carry);
        check({tag, " rom_addr_pre"}, 32'(rom_addr), 32'(pc_before));
        check({tag, " exec_fetch"}, 32'(exec), 32'(0));
        run       = 1'b1;
        alu_carry = alu;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        check({tag, " exec"}, 32'(exec), 32'(1));
        check({tag, " loads"}, 32'({load_a, load_b, load_out}), 32'(e_load));
        check({tag, " onehot"}, 32'($countones({load_a, load_b, load_out}) <= 1), 32'(1));
        if (e_src_chk) check({tag, " src_sel"}, 32'(src_sel), 32'(e_src));
        check({tag, " imm"}, 32'(imm), 32'(e_imm));
        if (drop) run = 1'b0;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        check({tag, " rom_addr_post"}, 32'(rom_addr), 32'(e_pc));
        check({tag, " carry"}, 32'(carry_flag), 32'(e_carry));
        check({tag, " exec_after"}, 32'(exec), 32'(0));
    endtask

    // Reference model: one instruction at the architectural level
    task automatic model_step(input logic alu, input logic drop);
        logic [7:0] w;
        logic [3:0] op, im, npc;
        logic [2:0] e_load;
        logic       nc;
        w  = rom[m_pc];
        op = w[7:4];
        im = w[3:0];
        case (dest_tab[op])
            1:       e_load = 3'b100;
            2:       e_load = 3'b010;
            3:       e_load = 3'b001;
            default: e_load = 3'b000;
        endcase
        if (op == 4'hF || (op == 4'hE && !m_carry)) npc = im;
        else npc = 4'((32'(m_pc) + 1) % 16);
        nc = (op == 4'h0 || op == 4'h5) ? alu : 1'b0;
        apply_instr("rnd", m_pc, alu, drop, e_load, 2'(src_tab[op]),
                    (op != 4'hE && op != 4'hF), im, npc, nc);
        m_pc    = npc;
        m_carry = nc;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            dest_tab[i] = 0;
            src_tab[i]  = 3;
            rom[i]      = 8'h80;
        end
        dest_tab[0]  = 1; src_tab[0]  = 0;
        dest_tab[1]  = 1; src_tab[1]  = 1;
        dest_tab[2]  = 1; src_tab[2]  = 2;
        dest_tab[3]  = 1; src_tab[3]  = 3;
        dest_tab[4]  = 2; src_tab[4]  = 0;
        dest_tab[5]  = 2; src_tab[5]  = 1;
        dest_tab[6]  = 2; src_tab[6]  = 2;
        dest_tab[7]  = 2; src_tab[7]  = 3;
        dest_tab[9]  = 3; src_tab[9]  = 1;
        dest_tab[11] = 3; src_tab[11] = 3;

        tbl[0]  = '{4'h0, 8'h05, 1'b1, 1'b0, 3'b100, 2'd0, 1'b1, 4'h1, 1'b1};
        tbl[1]  = '{4'h1, 8'hE9, 1'b0, 1'b0, 3'b000, 2'd3, 1'b0, 4'h2, 1'b0};
        tbl[2]  = '{4'h2, 8'hE7, 1'b0, 1'b0, 3'b000, 2'd3, 1'b0, 4'h7, 1'b0};
        tbl[3]  = '{4'h7, 8'hFF, 1'b0, 1'b1, 3'b000, 2'd3, 1'b0, 4'hF, 1'b0};
        tbl[4]  = '{4'hF, 8'h80, 1'b1, 1'b0, 3'b000, 2'd3, 1'b1, 4'h0, 1'b0};
        tbl[5]  = '{4'h0, 8'h05, 1'b0, 1'b0, 3'b100, 2'd0, 1'b1, 4'h1, 1'b0};
        tbl[6]  = '{4'h1, 8'hE9, 1'b1, 1'b0, 3'b000, 2'd3, 1'b0, 4'h9, 1'b0};
        tbl[7]  = '{4'h9, 8'h5A, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1, 4'hA, 1'b1};
        tbl[8]  = '{4'hA, 8'h9C, 1'b1, 1'b0, 3'b001, 2'd1, 1'b1, 4'hB, 1'b0};
        tbl[9]  = '{4'hB, 8'hB4, 1'b0, 1'b0, 3'b001, 2'd3, 1'b1, 4'hC, 1'b0};
        tbl[10] = '{4'hC, 8'h46, 1'b0, 1'b0, 3'b010, 2'd0, 1'b1, 4'hD, 1'b0};
        tbl[11] = '{4'hD, 8'h21, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 4'hE, 1'b0};
        tbl[12] = '{4'hE, 8'h62, 1'b0, 1'b0, 3'b010, 2'd2, 1'b1, 4'hF, 1'b0};
        tbl[13] = '{4'hF, 8'h80, 1'b0, 1'b0, 3'b000, 2'd3, 1'b1, 4'h0, 1'b0};

        reset     = 1'b1;
        run       = 1'b0;
        alu_carry = 1'b0;
        repeat (3) @(posedge clk_cpu);
        @(negedge clk_cpu);
        check("reset rom_addr", 32'(rom_addr), 32'(0));
        check("reset carry", 32'(carry_flag), 32'(0));
        check("reset exec", 32'(exec), 32'(0));
        check("reset loads", 32'({load_a, load_b, load_out}), 32'(0));
        reset = 1'b0;

        // Held in FETCH while run is low
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_cpu);
            @(negedge clk_cpu);
            check("idle exec", 32'(exec), 32'(0));
            check("idle rom_addr", 32'(rom_addr), 32'(0));
        end

        // MOV A,3 at address 0
        rom[0] = 8'h33;
        apply_instr("mov_a_3", 4'h0, 1'b0, 1'b0, 3'b100, 2'd3, 1'b1, 4'h3, 4'h1, 1'b0);

        // Set carry, then reset in the middle of MOV A,3
        rom[1] = 8'h05;
        rom[2] = 8'h33;
        apply_instr("add_a_5", 4'h1, 1'b1, 1'b0, 3'b100, 2'd0, 1'b1, 4'h5, 4'h2, 1'b1);
        run = 1'b1;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        check("pre_rst load_a", 32'(load_a), 32'(1));
        reset = 1'b1;
        #1;
        check("mid_rst load_a", 32'(load_a), 32'(0));
        check("mid_rst exec", 32'(exec), 32'(0));
        check("mid_rst rom_addr", 32'(rom_addr), 32'(0));
        check("mid_rst carry", 32'(carry_flag), 32'(0));
        run = 1'b0;
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_cpu);
            @(negedge clk_cpu);
            check("post_rst loads", 32'({load_a, load_b, load_out}), 32'(0));
            check("post_rst exec", 32'(exec), 32'(0));
        end

        // OUT B after a hold
        rom[0] = 8'h93;
        apply_instr("out_b", 4'h0, 1'b0, 1'b0, 3'b001, 2'd1, 1'b1, 4'h3, 4'h1, 1'b0);

        // Table-driven program
        run = 1'b0;
        pulse_reset();
        for (int i = 0; i < 14; i++) rom[tbl[i].pc] = tbl[i].word;
        for (int i = 0; i < 14; i++) begin
            apply_instr($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].alu, tbl[i].drop,
                        tbl[i].load, tbl[i].src, tbl[i].src_chk, tbl[i].word[3:0],
                        tbl[i].npc, tbl[i].ncarry);
        end

        // Random program stream with random holds and run drops
        m_pc    = 4'h0;
        m_carry = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (n % 40 == 0)
                for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                run = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk_cpu);
                    @(negedge clk_cpu);
                    check("hold exec", 32'(exec), 32'(0));
                    check("hold rom_addr", 32'(rom_addr), 32'(m_pc));
                end
            end
            model_step(1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
